// File: rtl/genius_vga_pkg.sv
// Shared constants and helpers for the Genius VGA front end: 640x480@60 timing,
// quadrant split points, default palette and RGB444 -> RGB888 expansion.
package genius_vga_pkg;

  typedef logic [9:0]       coord_t;
  typedef logic [11:0]      rgb444_t;
  typedef logic [3:0][11:0] palette_t;  // index = quadrant, packed {Q3,Q2,Q1,Q0}

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    QUAD_TL = 2'd0,
    QUAD_TR = 2'd1,
    QUAD_BL = 2'd2,
    QUAD_BR = 2'd3
  } quadrant_e;

  localparam coord_t H_ACTIVE = 10'd640;
  localparam coord_t H_FP     = 10'd16;
  localparam coord_t H_SYNC   = 10'd96;
  localparam coord_t H_BP     = 10'd48;
  localparam coord_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam coord_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam coord_t V_ACTIVE = 10'd480;
  localparam coord_t V_FP     = 10'd10;
  localparam coord_t V_SYNC   = 10'd2;
  localparam coord_t V_BP     = 10'd33;
  localparam coord_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam coord_t H_SPLIT = 10'd320;
  localparam coord_t V_SPLIT = 10'd240;

  localparam palette_t DEFAULT_PALETTE = {12'h00A, 12'hAA0, 12'hA00, 12'h0A0};

  function automatic quadrant_e quadrant_of(coord_t h, coord_t v);
    return quadrant_e'({v >= V_SPLIT, h >= H_SPLIT});
  endfunction

  function automatic rgb888_t expand(rgb444_t c);
    rgb888_t o;
    o.r = {c[11:8], c[11:8]};
    o.g = {c[7:4],  c[7:4]};
    o.b = {c[3:0],  c[3:0]};
    return o;
  endfunction

endpackage

// File: rtl/genius_vga_if.sv
// Timing bundle from the raster generator to the pixel path: live counters
// plus the registered sync/enable/frame-start signals.
interface genius_vga_if;
  import genius_vga_pkg::*;

  coord_t h;
  coord_t v;
  logic   hs;
  logic   vs;
  logic   disp_en;
  logic   frame_start;

  modport master (output h, v, hs, vs, disp_en, frame_start);
  modport slave  (input  h, v, hs, vs, disp_en, frame_start);

endinterface

// File: rtl/vga_timing.sv
// 800x525 raster counters with registered HS/VS/DISP_EN and a frame-start strobe;
// registered outputs describe the pixel the counters held one cycle earlier.
module vga_timing
  import genius_vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  genius_vga_if.master tmg
);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   hs;
  logic   vs;
  logic   disp_en;
  logic   frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      disp_en     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let the decode below see the pre-edge counters.
      hs          <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
      vs          <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
      disp_en     <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);

      if (h_cnt == H_TOTAL - 10'd1) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign tmg.h           = h_cnt;
  assign tmg.v           = v_cnt;
  assign tmg.hs          = hs;
  assign tmg.vs          = vs;
  assign tmg.disp_en     = disp_en;
  assign tmg.frame_start = frame_start;

endmodule

// File: rtl/genius_top_level.sv
// Genius (Simon) display front end: VGA raster, writable four-quadrant palette,
// quadrant colour mux and nibble-to-byte expansion onto the DAC pins.
module genius_top_level
  import genius_vga_pkg::*;
(
  input  logic        CLOCK_25,
  input  logic        CLOCK_50,
  input  logic [0:0]  SW,
  input  logic        wren,
  input  logic [47:0] data,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        DISP_EN,
  output logic        VGA_CLK,
  output logic        c1,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  logic      rst;
  palette_t  palette;
  rgb888_t   pixel;
  quadrant_e quad;
  logic      active;
  logic      unused_clock_50;

  assign rst             = SW[0];
  assign unused_clock_50 = CLOCK_50;

  genius_vga_if tmg ();

  vga_timing u_timing (
    .clk (CLOCK_25),
    .rst (rst),
    .tmg (tmg.master)
  );

  always_comb begin
    quad   = quadrant_of(tmg.h, tmg.v);
    active = (tmg.h < H_ACTIVE) && (tmg.v < V_ACTIVE);
  end

  always_ff @(posedge CLOCK_25) begin
    // NOTE: reset is tested before wren so a same-edge write cannot beat the default palette.
    if (rst) begin
      palette <= DEFAULT_PALETTE;
      pixel   <= '0;
    end else begin
      if (wren) palette <= data;
      pixel <= active ? expand(palette[quad]) : '0;
    end
  end

  assign VGA_HS      = tmg.hs;
  assign VGA_VS      = tmg.vs;
  assign DISP_EN     = tmg.disp_en;
  assign VGA_BLANK_N = tmg.disp_en;
  assign c1          = tmg.frame_start;
  assign VGA_CLK     = CLOCK_25;
  assign VGA_R       = pixel.r;
  assign VGA_G       = pixel.g;
  assign VGA_B       = pixel.b;

endmodule

// File: tb/tb_genius_top_level.sv
// Directed bench for genius_top_level: a cycle model pushes expected outputs into
// a scoreboard each edge, plus spot checks on sync positions, quadrants and palette.
module tb_genius_top_level;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       bn;
    logic       c1;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;

  localparam logic [47:0] DEF_PAL   = 48'h00A_AA0_A00_0A0;
  localparam out_t        RESET_OUT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, bn: 1'b0, c1: 1'b0,
                                        r: 8'h00, g: 8'h00, b: 8'h00};

  logic        clk   = 1'b0;
  logic        clk50 = 1'b0;
  logic [0:0]  sw    = 1'b1;
  logic        wren  = 1'b0;
  logic [47:0] data  = '0;
  logic        vga_hs, vga_vs, vga_blank_n, disp_en, vga_clk, c1;
  logic [7:0]  vga_r, vga_g, vga_b;

  int    checks   = 0;
  int    failures = 0;
  out_t  sb[$];
  out_t  act;
  int    sb_errs  = 0;
  string first_err = "";

  int          mh = 0, mv = 0, px_h = -1, px_v = -1;
  logic [47:0] pal_m = DEF_PAL;
  logic [9:0]  poke_h, poke_v;
  logic        vclk_hi, vclk_lo;

  int   cyc, fall1, fall2, rise1, de_cnt, c1_cnt, vs_low, vs_fall_h, vs_fall_v;
  int   c1_h, c1_v;
  logic prev_hs, prev_vs;

  always #20 clk = ~clk;
  always #10 clk50 = ~clk50;

  genius_top_level dut (
    .CLOCK_25    (clk),
    .CLOCK_50    (clk50),
    .SW          (sw),
    .wren        (wren),
    .data        (data),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .DISP_EN     (disp_en),
    .VGA_CLK     (vga_clk),
    .c1          (c1),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b)
  );

  function automatic out_t model(int h, int v, logic [47:0] p);
    out_t        o;
    logic [11:0] c;
    int          q;
    o.de = (h < 640) && (v < 480);
    o.bn = o.de;
    o.hs = !((h >= 656) && (h < 752));
    o.vs = !((v >= 490) && (v < 492));
    o.c1 = (h == 0) && (v == 0);
    q    = ((v >= 240) ? 2 : 0) + ((h >= 320) ? 1 : 0);
    c    = p[q*12 +: 12];
    o.r  = o.de ? {c[11:8], c[11:8]} : 8'h00;
    o.g  = o.de ? {c[7:4],  c[7:4]}  : 8'h00;
    o.b  = o.de ? {c[3:0],  c[3:0]}  : 8'h00;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    out_t e, got;
    if (sw[0]) begin
      e = RESET_OUT;
      mh = 0; mv = 0; pal_m = DEF_PAL; px_h = -1; px_v = -1;
    end else begin
      e = model(mh, mv, pal_m);
      px_h = mh; px_v = mv;
      if (wren) pal_m = data;
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv++;
        if (mv == 525) mv = 0;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    vclk_hi = vga_clk;
    got = {vga_hs, vga_vs, disp_en, vga_blank_n, c1, vga_r, vga_g, vga_b};
    act = got;
    e   = sb.pop_front();
    if (got !== e) begin
      sb_errs++;
      if (sb_errs == 1)
        first_err = $sformatf("px=(%0d,%0d) got=0x%0h exp=0x%0h", px_h, px_v, got, e);
    end
    @(negedge clk);
    #1;
    vclk_lo = vga_clk;
  endtask

  // Jump the raster counters so distant lines are reachable in a short run.
  task automatic poke(input int h, input int v);
    poke_h = 10'(h);
    poke_v = 10'(v);
    force dut.u_timing.h_cnt = poke_h;
    force dut.u_timing.v_cnt = poke_v;
    release dut.u_timing.h_cnt;
    release dut.u_timing.v_cnt;
    mh = h;
    mv = v;
  endtask

  function automatic logic [23:0] rgb_of(out_t o);
    return {o.r, o.g, o.b};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;

    // Reset held for five edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("reset_out_%0d", i), act, RESET_OUT);
    end

    // First two lines after release.
    sw = 1'b0;
    cyc = 0; fall1 = -1; fall2 = -1; rise1 = -1; de_cnt = 0; c1_cnt = 0; prev_hs = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check("first_pixel_de",  act.de, 1'b1);
        check("first_pixel_c1",  act.c1, 1'b1);
        check("first_pixel_rgb", rgb_of(act), 24'h00AA00);
        check("vga_clk_high", vclk_hi, 1'b1);
        check("vga_clk_low",  vclk_lo, 1'b0);
      end
      if (prev_hs && !act.hs) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!prev_hs && act.hs && rise1 < 0) rise1 = cyc;
      prev_hs = act.hs;
      if (cyc <= 800 && act.de) de_cnt++;
      if (act.c1) c1_cnt++;
      if (px_h == 319 && px_v == 0) check("q0_default_319_0", rgb_of(act), 24'h00AA00);
      if (px_h == 320 && px_v == 0) check("q1_default_320_0", rgb_of(act), 24'hAA0000);
    end
    check("hs_fall_line0", fall1, 657);
    check("hs_rise_line0", rise1, 753);
    check("hs_fall_line1", fall2, 1457);
    check("de_cycles_line0", de_cnt, 640);
    check("c1_pulses_two_lines", c1_cnt, 1);
    check("scoreboard_lines", sb_errs, 0);

    // Bottom-left and bottom-right defaults.
    poke(790, 239);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (px_h == 0 && px_v == 240) check("q2_default_0_240", rgb_of(act), 24'hAAAA00);
    end
    poke(630, 479);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (px_h == 639 && px_v == 479) check("q3_default_639_479", rgb_of(act), 24'h0000AA);
      if (px_h == 640 && px_v == 479) check("de_off_640_479", act.de, 1'b0);
    end

    // Vertical blanking and sync.
    poke(0, 488);
    vs_low = 0; vs_fall_h = -1; vs_fall_v = -1; de_cnt = 0; prev_vs = act.vs;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!act.vs) vs_low++;
      if (prev_vs && !act.vs && vs_fall_v < 0) begin
        vs_fall_h = px_h;
        vs_fall_v = px_v;
      end
      prev_vs = act.vs;
      if (act.de) de_cnt++;
    end
    check("vs_low_cycles", vs_low, 1600);
    check("vs_fall_line", vs_fall_v, 490);
    check("vs_fall_col", vs_fall_h, 0);
    check("de_off_lines_488_492", de_cnt, 0);

    // Frame wrap back to (0,0).
    poke(790, 524);
    c1_cnt = 0; c1_h = -1; c1_v = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (act.c1) begin
        c1_cnt++;
        c1_h = px_h;
        c1_v = px_v;
      end
      if (px_h == 0 && px_v == 0) check("wrap_pixel_0_0", rgb_of(act), 24'h00AA00);
    end
    check("c1_pulses_at_wrap", c1_cnt, 1);
    check("c1_pixel", {c1_h[15:0], c1_v[15:0]}, 32'h0);

    // Palette write in the middle of line 0.
    poke(100, 0);
    wren = 1'b1;
    data = 48'hFFF_000_F0F_123;
    tick();
    wren = 1'b0;
    data = '0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (px_h == 102 && px_v == 0) check("q0_written", rgb_of(act), 24'h112233);
      if (px_h == 400 && px_v == 0) check("q1_written", rgb_of(act), 24'hFF00FF);
    end
    poke(310, 240);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (px_h == 315 && px_v == 240) begin
        check("q2_written", rgb_of(act), 24'h000000);
        check("q2_written_de", act.de, 1'b1);
      end
      if (px_h == 325 && px_v == 240) check("q3_written", rgb_of(act), 24'hFFFFFF);
    end

    // Reset mid-frame with a simultaneous write: defaults must win.
    sw   = 1'b1;
    wren = 1'b1;
    data = 48'h123_456_789_ABC;
    tick();
    check("midframe_reset_out", act, RESET_OUT);
    tick();
    sw   = 1'b0;
    wren = 1'b0;
    data = '0;
    tick();
    check("restart_c1", act.c1, 1'b1);
    check("restart_q0_default", rgb_of(act), 24'h00AA00);
    for (int i = 0; i < 330; i++) begin
      tick();
      if (px_h == 320 && px_v == 0) check("restart_q1_default", rgb_of(act), 24'hAA0000);
    end

    if (sb_errs != 0) $display("first scoreboard divergence: %s", first_err);
    check("scoreboard_total", sb_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
